// File: rtl/rf_wb_arbiter_pkg.sv
// Shared register-file writeback types and constants used by the arbiter,
// its result buffer and anything that talks to the RF write port.
package rf_wb_arbiter_pkg;

    localparam int CPU_ADDR_W = 5;
    localparam int CPU_XLEN   = 32;

    typedef logic [CPU_ADDR_W-1:0] reg_addr_t;
    typedef logic [CPU_XLEN-1:0]   xlen_t;

    localparam reg_addr_t REG_ZERO = '0;

    typedef struct packed {
        logic      we;
        reg_addr_t addr;
        xlen_t     data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of writeback, secondary-result, issue, hazard-query and RF write
// signals around the register-file write-port arbiter.
interface rf_wb_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATAWIDTH  = 32
) ();
    logic                  pipe_wen;
    logic [ADDR_WIDTH-1:0] pipe_waddr;
    logic [DATAWIDTH-1:0]  pipe_wdata;

    logic                  sec_valid;
    logic                  sec_ready;
    logic [ADDR_WIDTH-1:0] sec_waddr;
    logic [DATAWIDTH-1:0]  sec_wdata;

    logic                  iss_valid;
    logic [ADDR_WIDTH-1:0] iss_rd;

    logic [ADDR_WIDTH-1:0] q_rs1;
    logic [ADDR_WIDTH-1:0] q_rs2;
    logic [ADDR_WIDTH-1:0] q_rd;
    logic                  hz_rs1;
    logic                  hz_rs2;
    logic                  hz_rd;

    logic                  pipe_stall;

    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATAWIDTH-1:0]  rf_wdata;

    modport master (
        output pipe_wen, pipe_waddr, pipe_wdata,
        output sec_valid, sec_waddr, sec_wdata,
        output iss_valid, iss_rd,
        output q_rs1, q_rs2, q_rd,
        input  sec_ready, hz_rs1, hz_rs2, hz_rd, pipe_stall,
        input  rf_wen, rf_waddr, rf_wdata
    );

    modport slave (
        input  pipe_wen, pipe_waddr, pipe_wdata,
        input  sec_valid, sec_waddr, sec_wdata,
        input  iss_valid, iss_rd,
        input  q_rs1, q_rs2, q_rd,
        output sec_ready, hz_rs1, hz_rs2, hz_rd, pipe_stall,
        output rf_wen, rf_waddr, rf_wdata
    );

endinterface

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// Small synchronous FIFO for secondary-unit results. Async reset clears the
// control state only; storage is never reset.
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok, pop_ok;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        push_ok  = push && !full_q;
        pop_ok   = pop && !empty_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = empty_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority over
// buffered secondary results, with a starvation guard and a pending-write scoreboard.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = CPU_ADDR_W,
    parameter int DATAWIDTH  = CPU_XLEN,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input logic                clk,
    input logic                rst,
    rf_wb_arbiter_if.slave     bus
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int STV_W  = $clog2(STARVE_MAX + 1);
    localparam int NREGS  = 1 << ADDR_WIDTH;
    localparam int ENTRY_W = ADDR_WIDTH + DATAWIDTH;

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

    logic [ENTRY_W-1:0]    head;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATAWIDTH-1:0]  head_data;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic                  sec_ready;
    logic                  sec_push;
    logic                  head_pop;

    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATAWIDTH-1:0]  rf_wdata;

    logic [NREGS-1:0]      pending_q, pending_d;
    logic [STV_W-1:0]      starve_q, starve_d;
    logic                  stall_q, stall_d;

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (sec_push),
        .push_data ({bus.sec_waddr, bus.sec_wdata}),
        .pop       (head_pop),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign {head_addr, head_data} = head;

    // Readiness depends only on the registered count, so a result can never
    // bypass straight from the secondary bus to the RF port.
    always_comb begin
        sec_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
        sec_push  = bus.sec_valid && sec_ready;
        head_pop  = !bus.pipe_wen && !fifo_empty;
        rf_wen    = 1'b0;
        rf_waddr  = bus.pipe_waddr;
        rf_wdata  = bus.pipe_wdata;
        if (bus.pipe_wen) begin
            rf_wen = (bus.pipe_waddr != ZERO_ADDR);
        end else if (!fifo_empty) begin
            rf_waddr = head_addr;
            rf_wdata = head_data;
            rf_wen   = (head_addr != ZERO_ADDR);
        end
        if (rst) begin
            rf_wen = 1'b0;
        end
    end

    // Set after clear so a same-cycle issue to the register being retired wins.
    always_comb begin
        pending_d = pending_q;
        if (head_pop) begin
            pending_d[head_addr] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_rd != ZERO_ADDR)) begin
            pending_d[bus.iss_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || head_pop) begin
            starve_d = '0;
        end else if (starve_q != STV_W'(STARVE_MAX)) begin
            starve_d = starve_q + STV_W'(1);
        end
        stall_d = (starve_d == STV_W'(STARVE_MAX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            starve_q  <= '0;
            stall_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            starve_q  <= starve_d;
            stall_q   <= stall_d;
        end
    end

    assign bus.sec_ready  = sec_ready;
    assign bus.rf_wen     = rf_wen;
    assign bus.rf_waddr   = rf_waddr;
    assign bus.rf_wdata   = rf_wdata;
    assign bus.pipe_stall = stall_q;
    assign bus.hz_rs1     = pending_q[bus.q_rs1];
    assign bus.hz_rs2     = pending_q[bus.q_rs2];
    assign bus.hz_rd      = pending_q[bus.q_rd];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus a randomized run checked
// against a queue-based model of the write port, scoreboard and starvation guard.
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATAWIDTH(DW)) bus ();

    rf_wb_arbiter #(
        .ADDR_WIDTH (AW),
        .DATAWIDTH  (DW),
        .FIFO_DEPTH (DEPTH),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: result buffer as a queue, pending set as a bit array,
    // and the number of consecutive cycles the oldest buffered result has waited.
    wb_req_t mq[$];
    bit      mpend[32];
    int      mwait;
    bit      mstall;

    function automatic bit exp_ready();
        return mq.size() < DEPTH;
    endfunction

    function automatic bit exp_wen();
        if (bus.pipe_wen) return bus.pipe_waddr != 0;
        if (mq.size() > 0) return mq[0].addr != 0;
        return 1'b0;
    endfunction

    function automatic logic [AW-1:0] exp_waddr();
        return bus.pipe_wen ? bus.pipe_waddr : mq[0].addr;
    endfunction

    function automatic logic [DW-1:0] exp_wdata();
        return bus.pipe_wen ? bus.pipe_wdata : mq[0].data;
    endfunction

    function automatic bit exp_hz(input logic [AW-1:0] a);
        return (a != 0) && mpend[a];
    endfunction

    function automatic void model_reset();
        mq.delete();
        foreach (mpend[i]) mpend[i] = 1'b0;
        mwait  = 0;
        mstall = 1'b0;
    endfunction

    function automatic void model_edge();
        int      sz;
        bit      popped;
        wb_req_t h;
        sz     = mq.size();
        popped = !bus.pipe_wen && (sz > 0);
        if (popped) begin
            h = mq.pop_front();
            mpend[h.addr] = 1'b0;
        end
        if (bus.iss_valid && bus.iss_rd != 0) mpend[bus.iss_rd] = 1'b1;
        if (bus.sec_valid && sz < DEPTH)
            mq.push_back(wb_req_t'{we: 1'b1, addr: bus.sec_waddr, data: bus.sec_wdata});
        if (popped || sz == 0) mwait = 0;
        else if (mwait < SMAX) mwait++;
        mstall = (mwait == SMAX);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        bus.pipe_wen = 1'b0; bus.pipe_waddr = '0; bus.pipe_wdata = '0;
        bus.sec_valid = 1'b0; bus.sec_waddr = '0; bus.sec_wdata = '0;
        bus.iss_valid = 1'b0; bus.iss_rd = '0;
        bus.q_rs1 = '0; bus.q_rs2 = '0; bus.q_rd = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        total++; if (bus.sec_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b want=1", bus.sec_ready); end
        total++; if (bus.rf_wen !== 1'b0) begin bad++; $display("FAIL rst_wen got=%0b want=0", bus.rf_wen); end
        total++; if (bus.pipe_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b want=0", bus.pipe_stall); end
        rst = 1'b0;
        tick();
        // Build state: pending[5], two buffered results, then reset mid-stream.
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
        bus.pipe_wen = 1'b1; bus.pipe_waddr = 5'd3; bus.pipe_wdata = 32'h3333_0000;
        tick();
        bus.iss_valid = 1'b0;
        bus.sec_valid = 1'b1; bus.sec_waddr = 5'd10; bus.sec_wdata = 32'h0000_0010;
        tick();
        bus.sec_waddr = 5'd11; bus.sec_wdata = 32'h0000_0011;
        tick();
        bus.sec_valid = 1'b0; bus.q_rd = 5'd5; bus.q_rs1 = 5'd5;
        #2;
        total++; if (bus.sec_ready !== 1'b0) begin bad++; $display("FAIL pre_rst_ready got=%0b want=0", bus.sec_ready); end
        total++; if (bus.hz_rd !== 1'b1) begin bad++; $display("FAIL pre_rst_hz got=%0b want=1", bus.hz_rd); end
        rst = 1'b1;
        #1;
        model_reset();
        total++; if (bus.sec_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%0b want=1", bus.sec_ready); end
        total++; if (bus.hz_rd !== 1'b0 || bus.hz_rs1 !== 1'b0) begin bad++; $display("FAIL midrst_hz got=%0b%0b want=00", bus.hz_rd, bus.hz_rs1); end
        total++; if (bus.rf_wen !== 1'b0) begin bad++; $display("FAIL midrst_wen got=%0b want=0", bus.rf_wen); end
        total++; if (bus.pipe_stall !== 1'b0) begin bad++; $display("FAIL midrst_stall got=%0b want=0", bus.pipe_stall); end
        rst = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_idle_sec();
        idle_inputs();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd7; bus.q_rd = 5'd7;
        #2;
        total++; if (bus.hz_rd !== 1'b0) begin bad++; $display("FAIL idle_hz_before got=%0b want=0", bus.hz_rd); end
        tick();
        bus.iss_valid = 1'b0;
        bus.sec_valid = 1'b1; bus.sec_waddr = 5'd7; bus.sec_wdata = 32'hDEAD_BEEF;
        #2;
        total++; if (bus.sec_ready !== 1'b1 || bus.rf_wen !== 1'b0) begin bad++; $display("FAIL idle_accept got rdy=%0b wen=%0b want rdy=1 wen=0", bus.sec_ready, bus.rf_wen); end
        total++; if (bus.hz_rd !== 1'b1) begin bad++; $display("FAIL idle_hz_pending got=%0b want=1", bus.hz_rd); end
        tick();
        bus.sec_valid = 1'b0;
        #2;
        total++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd7 || bus.rf_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL idle_write got=%0b/%0d/%h want=1/7/deadbeef", bus.rf_wen, bus.rf_waddr, bus.rf_wdata); end
        total++; if (bus.hz_rd !== 1'b1) begin bad++; $display("FAIL idle_hz_at_write got=%0b want=1", bus.hz_rd); end
        tick();
        #2;
        total++; if (bus.rf_wen !== 1'b0 || bus.hz_rd !== 1'b0) begin bad++; $display("FAIL idle_after got wen=%0b hz=%0b want 0/0", bus.rf_wen, bus.hz_rd); end
        tick();
    endtask

    task automatic test_contention();
        idle_inputs();
        bus.pipe_wen = 1'b1; bus.pipe_waddr = 5'd3; bus.pipe_wdata = $urandom();
        bus.sec_valid = 1'b1; bus.sec_waddr = 5'd9; bus.sec_wdata = 32'h0000_0999;
        tick();
        bus.sec_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            bus.pipe_wdata = $urandom();
            #2;
            total++; if (bus.pipe_stall !== 1'b0 || bus.rf_waddr !== 5'd3 || bus.rf_wdata !== bus.pipe_wdata) begin bad++; $display("FAIL cont_wait%0d got stall=%0b addr=%0d want stall=0 addr=3", k, bus.pipe_stall, bus.rf_waddr); end
            tick();
        end
        #1;
        total++; if (bus.pipe_stall !== 1'b1) begin bad++; $display("FAIL cont_stall got=%0b want=1", bus.pipe_stall); end
        bus.pipe_wen = 1'b0;
        #1;
        total++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd9 || bus.rf_wdata !== 32'h0000_0999) begin bad++; $display("FAIL cont_drain got=%0b/%0d/%h want=1/9/999", bus.rf_wen, bus.rf_waddr, bus.rf_wdata); end
        tick();
        bus.pipe_wen = 1'b1;
        #2;
        total++; if (bus.pipe_stall !== 1'b0 || bus.rf_waddr !== 5'd3) begin bad++; $display("FAIL cont_release got stall=%0b addr=%0d want 0/3", bus.pipe_stall, bus.rf_waddr); end
        tick();
        idle_inputs();
    endtask

    task automatic test_full_fifo();
        idle_inputs();
        bus.pipe_wen = 1'b1; bus.pipe_waddr = 5'd3; bus.pipe_wdata = 32'h3;
        bus.sec_valid = 1'b1; bus.sec_waddr = 5'd12; bus.sec_wdata = 32'hAAAA_0012;
        tick();
        bus.sec_waddr = 5'd13; bus.sec_wdata = 32'hBBBB_0013;
        #2;
        total++; if (bus.sec_ready !== 1'b1) begin bad++; $display("FAIL full_one got=%0b want=1", bus.sec_ready); end
        tick();
        bus.sec_waddr = 5'd14; bus.sec_wdata = 32'hCCCC_0014;
        #2;
        total++; if (bus.sec_ready !== 1'b0) begin bad++; $display("FAIL full_two got=%0b want=0", bus.sec_ready); end
        tick();
        bus.pipe_wen = 1'b0;
        #2;
        total++; if (bus.sec_ready !== 1'b0 || bus.rf_waddr !== 5'd12 || bus.rf_wdata !== 32'hAAAA_0012) begin bad++; $display("FAIL full_deq got rdy=%0b addr=%0d data=%h want 0/12/aaaa0012", bus.sec_ready, bus.rf_waddr, bus.rf_wdata); end
        tick();
        bus.pipe_wen = 1'b1;
        #2;
        total++; if (bus.sec_ready !== 1'b1) begin bad++; $display("FAIL full_reopen got=%0b want=1", bus.sec_ready); end
        tick();
        bus.sec_valid = 1'b0; bus.pipe_wen = 1'b0;
        #2;
        total++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd13 || bus.rf_wdata !== 32'hBBBB_0013) begin bad++; $display("FAIL full_second got=%0b/%0d/%h want=1/13/bbbb0013", bus.rf_wen, bus.rf_waddr, bus.rf_wdata); end
        tick();
        #2;
        total++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd14 || bus.rf_wdata !== 32'hCCCC_0014) begin bad++; $display("FAIL full_held got=%0b/%0d/%h want=1/14/cccc0014", bus.rf_wen, bus.rf_waddr, bus.rf_wdata); end
        tick();
        #2;
        total++; if (bus.rf_wen !== 1'b0 || bus.sec_ready !== 1'b1) begin bad++; $display("FAIL full_empty got wen=%0b rdy=%0b want 0/1", bus.rf_wen, bus.sec_ready); end
    endtask

    task automatic test_x0();
        idle_inputs();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
        tick();
        bus.iss_valid = 1'b0;
        #2;
        total++; if (bus.hz_rd !== 1'b0 || bus.hz_rs1 !== 1'b0 || bus.hz_rs2 !== 1'b0) begin bad++; $display("FAIL x0_hz got=%0b%0b%0b want=000", bus.hz_rs1, bus.hz_rs2, bus.hz_rd); end
        bus.sec_valid = 1'b1; bus.sec_waddr = 5'd0; bus.sec_wdata = 32'h0000_1234;
        tick();
        bus.sec_waddr = 5'd6; bus.sec_wdata = 32'h0000_0066;
        #2;
        total++; if (bus.rf_wen !== 1'b0) begin bad++; $display("FAIL x0_sec_wen got=%0b want=0", bus.rf_wen); end
        tick();
        bus.sec_valid = 1'b0;
        #2;
        total++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd6 || bus.rf_wdata !== 32'h66) begin bad++; $display("FAIL x0_next got=%0b/%0d/%h want=1/6/66", bus.rf_wen, bus.rf_waddr, bus.rf_wdata); end
        tick();
        bus.pipe_wen = 1'b1; bus.pipe_waddr = 5'd0; bus.pipe_wdata = 32'hFFFF_FFFF;
        #2;
        total++; if (bus.rf_wen !== 1'b0) begin bad++; $display("FAIL x0_pipe_wen got=%0b want=0", bus.rf_wen); end
        tick();
        idle_inputs();
    endtask

    task automatic test_collision();
        idle_inputs();
        bus.q_rd = 5'd4;
        bus.sec_valid = 1'b1; bus.sec_waddr = 5'd4; bus.sec_wdata = 32'h0000_0044;
        tick();
        bus.sec_valid = 1'b0;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd4;
        #2;
        total++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd4) begin bad++; $display("FAIL coll_write got=%0b/%0d want=1/4", bus.rf_wen, bus.rf_waddr); end
        tick();
        bus.iss_valid = 1'b0;
        #2;
        total++; if (bus.hz_rd !== 1'b1) begin bad++; $display("FAIL coll_set_wins got=%0b want=1", bus.hz_rd); end
        bus.sec_valid = 1'b1; bus.sec_wdata = 32'h0000_0444;
        tick();
        bus.sec_valid = 1'b0;
        tick();
        #2;
        total++; if (bus.hz_rd !== 1'b0) begin bad++; $display("FAIL coll_cleared got=%0b want=0", bus.hz_rd); end
        tick();
    endtask

    task automatic test_random();
        int issued[$];
        bit acc;
        int r;
        idle_inputs();
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.pipe_wen   = !mstall && ($urandom_range(0, 2) != 0);
            bus.pipe_waddr = AW'($urandom_range(0, 31));
            bus.pipe_wdata = $urandom();
            if (!bus.sec_valid && $urandom_range(0, 2) == 0) begin
                bus.sec_valid = 1'b1;
                if (issued.size() > 0 && $urandom_range(0, 3) != 0) bus.sec_waddr = AW'(issued.pop_front());
                else bus.sec_waddr = AW'($urandom_range(0, 31));
                bus.sec_wdata = $urandom();
            end
            r = $urandom_range(0, 31);
            bus.iss_valid = ($urandom_range(0, 3) == 0) && !mpend[r];
            bus.iss_rd    = AW'(r);
            if (bus.iss_valid && r != 0) issued.push_back(r);
            bus.q_rs1 = AW'($urandom_range(0, 31));
            bus.q_rs2 = AW'($urandom_range(0, 31));
            bus.q_rd  = (issued.size() > 0) ? AW'(issued[0]) : AW'($urandom_range(0, 31));
            #2;
            total++; if (bus.sec_ready !== exp_ready()) begin bad++; $display("FAIL rnd_ready c=%0d got=%0b want=%0b", cyc, bus.sec_ready, exp_ready()); end
            total++; if (bus.pipe_stall !== mstall) begin bad++; $display("FAIL rnd_stall c=%0d got=%0b want=%0b", cyc, bus.pipe_stall, mstall); end
            total++; if (bus.rf_wen !== exp_wen()) begin bad++; $display("FAIL rnd_wen c=%0d got=%0b want=%0b", cyc, bus.rf_wen, exp_wen()); end
            if (exp_wen()) begin
                total++; if (bus.rf_waddr !== exp_waddr() || bus.rf_wdata !== exp_wdata()) begin bad++; $display("FAIL rnd_wdata c=%0d got=%0d/%h want=%0d/%h", cyc, bus.rf_waddr, bus.rf_wdata, exp_waddr(), exp_wdata()); end
            end
            total++; if (bus.hz_rs1 !== exp_hz(bus.q_rs1) || bus.hz_rs2 !== exp_hz(bus.q_rs2) || bus.hz_rd !== exp_hz(bus.q_rd)) begin bad++; $display("FAIL rnd_hz c=%0d got=%0b%0b%0b want=%0b%0b%0b", cyc, bus.hz_rs1, bus.hz_rs2, bus.hz_rd, exp_hz(bus.q_rs1), exp_hz(bus.q_rs2), exp_hz(bus.q_rd)); end
            acc = bus.sec_valid && exp_ready();
            tick();
            if (acc) bus.sec_valid = 1'b0;
        end
        idle_inputs();
        for (int k = 0; k < 4; k++) tick();
        total++; if (bus.sec_ready !== 1'b1 || mq.size() != 0) begin bad++; $display("FAIL rnd_drain got rdy=%0b left=%0d want 1/0", bus.sec_ready, mq.size()); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle_sec();
        test_contention();
        test_full_fifo();
        test_x0();
        test_collision();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Owns the register file's single write port and shares it between two writers: the in-order pipeline writeback and a long-latency secondary unit (mul/div, load return).
- Secondary results are buffered in a small FIFO; pipeline writes have priority, with a starvation guard.
- Keeps a 32-entry pending-write scoreboard so decode can stall on RAW/WAW against outstanding secondary writes.
- Sits between the writeback stage, the secondary unit and the RF write port.

Parameters:
- ADDR_WIDTH, 5: register address width (32 registers).
- DATAWIDTH, 32: register data width.
- FIFO_DEPTH, 2: secondary result buffer entries (power of 2, ≥2).
- STARVE_MAX, 4: cycles a non-empty FIFO head may wait before pipe_stall is raised.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- pipe_wen  in  1  pipeline writeback request (no backpressure)
- pipe_waddr  in  ADDR_WIDTH  pipeline destination
- pipe_wdata  in  DATAWIDTH  pipeline result
- sec_valid  in  1  secondary result valid
- sec_ready  out  1  secondary result accepted when valid&&ready
- sec_waddr  in  ADDR_WIDTH  secondary destination
- sec_wdata  in  DATAWIDTH  secondary result
- iss_valid  in  1  secondary op issued this cycle
- iss_rd  in  ADDR_WIDTH  destination of issued op
- q_rs1, q_rs2, q_rd  in  ADDR_WIDTH  decode hazard queries
- hz_rs1, hz_rs2, hz_rd  out  1  queried register has a pending secondary write
- pipe_stall  out  1  request that the pipeline withhold writeback
- rf_wen  out  1  RF write enable
- rf_waddr  out  ADDR_WIDTH  RF write address
- rf_wdata  out  DATAWIDTH  RF write data

Behaviour:
- Reset (async):
  - FIFO emptied; pending mask = 0; starve counter = 0; pipe_stall = 0.
  - Hence sec_ready = 1 and hz_* = 0. rf_wen = 0 while rst is high (gated).
- Write-port arbitration (combinational):
  - pipe_wen=1: rf_* = pipe_*.
  - Else if FIFO non-empty: rf_* = FIFO head, and head is dequeued at the clock edge.
  - Else rf_wen = 0.
  - The pipeline always wins, even while pipe_stall=1.
- Address 0:
  - Any write with address 0 (pipe or FIFO head) drives rf_wen = 0.
  - A FIFO head with address 0 is still dequeued.
- Secondary accept:
  - sec_ready = (count < FIFO_DEPTH), derived from registered count only. No same-cycle bypass from sec_* to rf_*.
  - Minimum latency is 1 cycle from accept to RF write.
  - Simultaneous enqueue and dequeue leaves count unchanged.
  - sec_valid is ignored when sec_ready=0. The producer must hold data stable until accepted.
- Scoreboard:
  - iss_valid && iss_rd≠0 sets pending[iss_rd].
  - A FIFO dequeue clears pending[head addr].
  - Same register set and cleared in the same cycle: set wins.
  - hz_x = pending[q_x], combinational, always 0 for q_x=0.
  - Issuing to an rd already pending is illegal; decode must stall on hz_rd.
  - The hazard drops the cycle after the RF write, when the RF already holds the new value.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and not dequeued, saturating at STARVE_MAX.
  - It clears on dequeue or when the FIFO is empty.
  - pipe_stall is registered and equals (counter == STARVE_MAX).
  - The pipeline honours pipe_stall by holding pipe_wen=0. The first such cycle drains the head and clears the counter, so pipe_stall falls the next cycle.
- No RF write-through; same-cycle RAW is decode's responsibility.
- Reset mid-operation discards buffered results and pending bits. The secondary unit is reset by the same rst.

Decomposition:
- Shared package cpu_pkg:
  - reg_addr_t (ADDR_WIDTH bits), xlen_t (DATAWIDTH bits).
  - Constant REG_ZERO = 0.
  - Struct wb_req_t {we, addr, data}, reused for pipe, sec and rf buses.
- Natural sub-module: wb_fifo, a synchronous FIFO with async reset, count output and registered full/empty.
- Scoreboard and arbiter stay in the top module.

Test Plan:
- Reset: assert rst mid-stream with FIFO holding 2 entries and pending[5]=1 → immediately sec_ready=1, hz_* = 0, rf_wen=0, pipe_stall=0.
- Idle secondary: iss rd=7; next cycle sec x7=0xDEADBEEF with pipe idle → rf_wen=1, rf_waddr=7 one cycle after accept. hz_rd(q_rd=7)=1 until the cycle after the write, then 0.
- Contention: pipe writes x3 every cycle while sec delivers x9 → FIFO holds it, pipe_stall=1 after 4 waiting cycles. The pipe drops wen one cycle → x9 written, pipe_stall=0 the next cycle.
- Full FIFO: 2 sec results queued under continuous pipe writes → sec_ready=0. The third result is held and accepted only after a dequeue.
- x0 handling: iss rd=0 → no pending bit. Sec result addr 0 → dequeued, rf_wen=0. pipe_wen with addr 0 → rf_wen=0.
- Set/clear collision: dequeue x4 in the same cycle as iss rd=4 → pending[4]=1 afterwards (hz_rd=1 for q_rd=4).
